// File: rtl/bus_mon_pkg.sv
// rtl/bus_mon_pkg.sv - shared FSM encoding and parameter legality check for the bus activity monitor
package bus_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2
  } bus_mon_state_e;

  // Returns 1 when the parameter set can be built. The edge counter must be
  // able to hold the threshold value when it is the one used for thresholding.
  function automatic bit bus_mon_params_ok(
    input int num_lines,
    input int sync_stages,
    input int act_threshold,
    input int idle_timeout,
    input int edge_cnt_width,
    input bit stats_en
  );
    bit ok;
    ok = (num_lines >= 1) && (sync_stages >= 2) && (act_threshold >= 1) &&
         (idle_timeout >= 2) && (edge_cnt_width >= 1) && (edge_cnt_width <= 30);
    if (stats_en && ok) begin
      ok = act_threshold < (1 << edge_cnt_width);
    end
    return ok;
  endfunction

endpackage

// File: rtl/synchronizer.sv
// rtl/synchronizer.sv - multi-bit, multi-stage flop chain for asynchronous inputs, reset to 0
module Synchronizer #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [STAGES-1:0][WIDTH-1:0] chain_q;
  logic [STAGES-1:0][WIDTH-1:0] chain_d;

  // Shift the raw input one stage further down the chain every cycle.
  always_comb begin
    chain_d    = chain_q;
    chain_d[0] = din;
    for (int i = 1; i < STAGES; i++) begin
      chain_d[i] = chain_q[i-1];
    end
  end

  // Chain registers, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign dout = chain_q[STAGES-1];

endmodule

// File: rtl/bus_activity_monitor.sv
// rtl/bus_activity_monitor.sv - bus line activity detector driving comm_active; BUS_MON_STATS_EN adds burst statistics
module bus_activity_monitor
  import bus_mon_pkg::*;
#(
  parameter int NUM_LINES      = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int ACT_THRESHOLD  = 3,
  parameter int IDLE_TIMEOUT   = 1200,
  parameter int EDGE_CNT_WIDTH = 16
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [NUM_LINES-1:0]      bus_lines,
  input  logic [NUM_LINES-1:0]      line_mask,
  output logic                      comm_active,
  output logic                      burst_done,
  output logic [EDGE_CNT_WIDTH-1:0] edge_count
);

`ifdef BUS_MON_STATS_EN
  localparam bit STATS_EN = 1'b1;
  localparam int CNT_W    = EDGE_CNT_WIDTH;
`else
  localparam bit STATS_EN = 1'b0;
  localparam int CNT_W    = $clog2(ACT_THRESHOLD + 1);
`endif

  localparam int TIMER_W = $clog2(IDLE_TIMEOUT);
  localparam int WARM_W  = $clog2(SYNC_STAGES + 2);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(IDLE_TIMEOUT - 1);
  localparam logic [WARM_W-1:0]  WARM_DONE  = WARM_W'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]   CNT_THRESH = CNT_W'(ACT_THRESHOLD);

  if (!bus_mon_params_ok(NUM_LINES, SYNC_STAGES, ACT_THRESHOLD, IDLE_TIMEOUT,
                         EDGE_CNT_WIDTH, STATS_EN)) begin : g_param_error
    $error("bus_activity_monitor: illegal parameter set");
  end

  logic [NUM_LINES-1:0] sync_lines;
  logic [NUM_LINES-1:0] hist_q, hist_d;
  logic [WARM_W-1:0]    warm_q, warm_d;
  bus_mon_state_e       state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 comm_active_q, comm_active_d;
  logic                 edge_det;

  Synchronizer #(
    .WIDTH  (NUM_LINES),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .din   (bus_lines),
    .dout  (sync_lines)
  );

  // History follows every line regardless of the mask, so a mask change
  // alone can never look like a transition.
  always_comb begin
    hist_d   = sync_lines;
    warm_d   = warm_q;
    if (warm_q != WARM_DONE) begin
      warm_d = warm_q + WARM_W'(1);
    end
    edge_det = (warm_q == WARM_DONE) && (|((sync_lines ^ hist_q) & line_mask));
  end

  // Glitch filter / activity FSM with idle timer; an edge always beats a timeout.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    cnt_d         = cnt_q;
    comm_active_d = (state_q == ST_ACTIVE);
    case (state_q)
      ST_IDLE: begin
        if (edge_det) begin
          cnt_d   = CNT_ONE;
          timer_d = '0;
          state_d = (ACT_THRESHOLD == 1) ? ST_ACTIVE : ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (edge_det) begin
          cnt_d   = cnt_q + CNT_ONE;
          timer_d = '0;
          if (cnt_d >= CNT_THRESH) begin
            state_d = ST_ACTIVE;
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (edge_det) begin
          timer_d = '0;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Core state registers; reset restarts warm-up and clears the burst state.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      hist_q        <= '0;
      warm_q        <= '0;
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      cnt_q         <= '0;
      comm_active_q <= 1'b0;
    end else begin
      hist_q        <= hist_d;
      warm_q        <= warm_d;
      state_q       <= state_d;
      timer_q       <= timer_d;
      cnt_q         <= cnt_d;
      comm_active_q <= comm_active_d;
    end
  end

  assign comm_active = comm_active_q;

`ifdef BUS_MON_STATS_EN
  logic burst_done_q, burst_done_d;

  // Burst end pulse lines up with the first cycle comm_active reads low.
  always_comb begin
    burst_done_d = comm_active_q & ~comm_active_d;
  end

  // Burst end pulse register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      burst_done_q <= 1'b0;
    end else begin
      burst_done_q <= burst_done_d;
    end
  end

  assign burst_done = burst_done_q;
  assign edge_count = cnt_q;
`else
  assign burst_done = 1'b0;
  assign edge_count = '0;
`endif

endmodule

// File: tb/tb_bus_activity_monitor.sv
// tb/tb_bus_activity_monitor.sv - scoreboard bench for bus_activity_monitor against a cycle-count reference model
module tb_bus_activity_monitor;

  localparam int NL      = 4;
  localparam int SS      = 2;
  localparam int TH      = 3;
  localparam int TO      = 16;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef BUS_MON_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [NL-1:0] bus_lines = 4'b1111;
  logic [NL-1:0] line_mask = 4'b1111;
  logic          comm_active;
  logic          burst_done;
  logic [CW-1:0] edge_count;

  bus_activity_monitor #(
    .NUM_LINES      (NL),
    .SYNC_STAGES    (SS),
    .ACT_THRESHOLD  (TH),
    .IDLE_TIMEOUT   (TO),
    .EDGE_CNT_WIDTH (CW)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .bus_lines   (bus_lines),
    .line_mask   (line_mask),
    .comm_active (comm_active),
    .burst_done  (burst_done),
    .edge_count  (edge_count)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic          comm;
    logic          burst;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  int   mon_cyc = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", name, mon_cyc, got, exp);
    end
  endtask

  // Reference model: pin samples per clock edge, activity rules expressed as
  // "edges seen in the burst" and "cycles since the last detected edge".
  initial begin : model
    logic [NL-1:0] smp[$];
    bit   seen_reset;
    int   st;          // 0 idle, 1 armed (below threshold), 2 active
    int   cnt, cyc, last_ed, len;
    bit   ed, exp_comm, prev_comm;
    exp_t e;
    seen_reset = 0;
    st = 0; cnt = 0; cyc = 0; last_ed = 0; prev_comm = 0;
    forever begin
      @(posedge sys_clk);
      if (!sys_rst_n) begin
        seen_reset = 1;
        smp.delete();
        st = 0; cnt = 0; cyc = 0; last_ed = 0; prev_comm = 0;
        e = '0;
        sb.push_back(e);
      end else if (seen_reset) begin
        len = smp.size();
        ed  = 0;
        if (len >= SS + 1) begin
          ed = |((smp[len-SS] ^ smp[len-SS-1]) & line_mask);
        end
        smp.push_back(bus_lines);
        if (smp.size() > 16) void'(smp.pop_front());
        cyc++;
        exp_comm = (st == 2);
        if (ed) begin
          last_ed = cyc;
          if (st == 0) begin
            cnt = 1;
            st  = (TH == 1) ? 2 : 1;
          end else begin
            if (cnt < CNT_MAX) cnt++;
            if (cnt >= TH) st = 2;
          end
        end else if (st != 0 && (cyc - last_ed) == TO) begin
          st = 0;
        end
        e.comm  = exp_comm;
        e.burst = STATS ? (prev_comm & ~exp_comm) : 1'b0;
        e.cnt   = STATS ? CW'(cnt) : '0;
        prev_comm = exp_comm;
        sb.push_back(e);
      end
    end
  end

  // Monitor: outputs are presented every cycle, compare each against the
  // oldest pending expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge sys_clk);
      mon_cyc++;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        pops++;
        chk("comm_active", 32'(comm_active), 32'(e.comm));
        chk("burst_done",  32'(burst_done),  32'(e.burst));
        chk("edge_count",  32'(edge_count),  32'(e.cnt));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic toggle(input int line, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      bus_lines[line] = ~bus_lines[line];
      idle(gap - 1);
    end
  endtask

  task automatic pulse_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin : stimulus
    int mode;
    idle(2);
    sys_rst_n = 1'b1;
    // lines idling high after reset
    idle(40);
    // single glitch on line 0
    toggle(0, 1, 1);
    idle(30);
    // four toggles of line 1, 3 cycles apart
    toggle(1, 4, 3);
    idle(30);
    // masked line 0, then unmask with line static
    line_mask = 4'b1110;
    toggle(0, 10, 2);
    idle(5);
    line_mask = 4'b1111;
    idle(30);
    // reset in the middle of a burst, then toggles during warm-up
    toggle(3, 5, 2);
    pulse_reset();
    bus_lines[3] = ~bus_lines[3];
    toggle(3, 4, 1);
    idle(30);
    // long fast burst for counter saturation
    toggle(2, 20, 2);
    idle(30);
    // randomized segments
    for (int s = 0; s < 60; s++) begin
      mode = $urandom_range(0, 4);
      line_mask = ($urandom_range(0, 3) == 0) ? NL'($urandom_range(0, 15)) : 4'b1111;
      case (mode)
        0: idle($urandom_range(1, 40));
        1: toggle($urandom_range(0, NL - 1), $urandom_range(1, 8), $urandom_range(1, 4));
        2: toggle($urandom_range(0, NL - 1), $urandom_range(1, 4), $urandom_range(TO - 2, TO + 2));
        3: begin
          for (int i = 0; i < 12; i++) begin
            @(negedge sys_clk);
            bus_lines = bus_lines ^ NL'($urandom_range(0, 15));
          end
        end
        default: begin
          if ($urandom_range(0, 2) == 0) pulse_reset();
          else idle($urandom_range(1, 5));
        end
      endcase
    end
    line_mask = 4'b1111;
    idle(40);
    @(negedge sys_clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("monitor_popped", 32'(pops > 500), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
